// File: rtl/fpu_f2i_arbiter_pkg.sv
// Shared types for the float-to-int arbiter: FSM state encoding, rounding-mode
// codes and the rounding-increment decision used by the converter.
package fpu_f2i_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Undefined codes never increment, so they truncate like RTZ.
    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic lsb, input logic rnd, input logic stk);
        logic inc;
        inc = 1'b0;
        case (rm)
            RM_RNE:  inc = rnd && (stk || lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign && (rnd || stk);
            RM_RUP:  inc = !sign && (rnd || stk);
            RM_RMM:  inc = rnd;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/FPU_Float_to_Int.sv
// Combinational float-to-int32 converter with rounding and invalid/inexact
// flags; outputs are zero unless a conversion is requested and reset is released.
module FPU_Float_to_Int
    import fpu_f2i_arbiter_pkg::*;
#(
    parameter int STD  = 15,
    parameter int MAN  = 9,
    parameter int EXP  = 4,
    parameter int BIAS = 15
) (
    input  logic         rst_l,
    input  logic         opcode_FI,
    input  logic         opcode_signed,
    input  logic         opcode_unsigned,
    input  logic [2:0]   rounding_mode,
    input  logic [STD:0] float_in,
    output logic [31:0]  int_out,
    output logic         invalid,
    output logic         inexact
);

    localparam int WW = MAN + 36;

    logic            sign_s;
    logic [EXP:0]    exp_s;
    logic [MAN:0]    man_s;
    logic [MAN+1:0]  sig_s;
    logic [WW-1:0]   wide_s;
    logic [33:0]     ip_s;
    logic            rnd_s;
    logic            stk_s;
    logic            big_s;
    logic            inc_s;
    logic [34:0]     mag_s;
    logic [34:0]     limit_s;
    logic            is_nan_s;
    logic            is_inf_s;
    int              unb_s;

    // Split the operand, align the significand around the binary point and round.
    always_comb begin
        sign_s   = float_in[STD];
        exp_s    = float_in[STD-1:MAN+1];
        man_s    = float_in[MAN:0];
        sig_s    = {(|exp_s), man_s};
        unb_s    = ((exp_s == {(EXP+1){1'b0}}) ? 32'sd1 : int'(exp_s)) - BIAS;
        wide_s   = {WW{1'b0}};
        big_s    = 1'b0;
        ip_s     = 34'd0;
        rnd_s    = 1'b0;
        stk_s    = 1'b0;
        if (unb_s > 32'sd32) begin
            big_s = 1'b1;
        end else if (unb_s < -32'sd1) begin
            // Magnitude below one half: only the sticky bit survives.
            stk_s = |sig_s;
        end else begin
            wide_s = {{34{1'b0}}, sig_s} << (unb_s + 32'sd1);
            ip_s   = wide_s[MAN+2 +: 34];
            rnd_s  = wide_s[MAN+1];
            stk_s  = |wide_s[MAN:0];
        end
        inc_s    = round_inc(rounding_mode, sign_s, ip_s[0], rnd_s, stk_s);
        mag_s    = {1'b0, ip_s} + {34'd0, inc_s};
        is_nan_s = (&exp_s) && (|man_s);
        is_inf_s = (&exp_s) && !(|man_s);
        if (opcode_signed) begin
            limit_s = sign_s ? 35'h0_8000_0000 : 35'h0_7FFF_FFFF;
        end else begin
            limit_s = sign_s ? 35'h0_0000_0000 : 35'h0_FFFF_FFFF;
        end
    end

    // Select saturated, special-case or rounded result and raise flags.
    always_comb begin
        int_out = 32'd0;
        invalid = 1'b0;
        inexact = 1'b0;
        if (!rst_l || !opcode_FI || (opcode_signed == opcode_unsigned)) begin
            int_out = 32'd0;
        end else if (is_nan_s || (is_inf_s && !sign_s)) begin
            invalid = 1'b1;
            int_out = opcode_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
        end else if (is_inf_s || big_s || (mag_s > limit_s)) begin
            invalid = 1'b1;
            if (sign_s) begin
                int_out = opcode_signed ? 32'h8000_0000 : 32'h0000_0000;
            end else begin
                int_out = opcode_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            end
        end else begin
            inexact = rnd_s || stk_s;
            int_out = sign_s ? (~mag_s[31:0] + 32'd1) : mag_s[31:0];
        end
    end

endmodule

// File: rtl/fpu_f2i_arbiter.sv
// Two-requester round-robin front end for a single float-to-int converter.
// Optional sticky flag accumulator enabled by defining F2I_FLAG_ACCUM_EN.
module fpu_f2i_arbiter
    import fpu_f2i_arbiter_pkg::*;
#(
    parameter int STD  = 15,
    parameter int MAN  = 9,
    parameter int EXP  = 4,
    parameter int BIAS = 15
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [STD:0] req0_float,
    input  logic [2:0]   req0_rm,
    input  logic         req0_signed,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [STD:0] req1_float,
    input  logic [2:0]   req1_rm,
    input  logic         req1_signed,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [31:0]  rsp_int,
    output logic         rsp_invalid,
    output logic         rsp_inexact,
    input  logic         flag_clr,
    output logic [1:0]   fflags_acc
);

    state_e          state_r;
    state_e          state_s;
    logic            prio_r;
    logic            grant0_s;
    logic            grant1_s;
    logic            accept_s;
    logic            opcode_fi_s;
    logic            opcode_unsigned_s;
    logic [STD:0]    op_float_r;
    logic [2:0]      op_rm_r;
    logic            op_signed_r;
    logic            rsp_id_r;
    logic [31:0]     rsp_int_r;
    logic            rsp_invalid_r;
    logic            rsp_inexact_r;
    logic [31:0]     cvt_int_s;
    logic            cvt_invalid_s;
    logic            cvt_inexact_s;
    logic            handshake_s;

    // Grant selection, next-state and converter control.
    always_comb begin
        grant0_s          = req0_valid && (!req1_valid || !prio_r);
        grant1_s          = req1_valid && (!req0_valid || prio_r);
        state_s           = state_r;
        req0_ready        = 1'b0;
        req1_ready        = 1'b0;
        accept_s          = 1'b0;
        opcode_fi_s       = 1'b0;
        opcode_unsigned_s = !op_signed_r;
        case (state_r)
            IDLE: begin
                // Ready is masked while reset is held so it reads low during reset.
                req0_ready = rst_l && grant0_s;
                req1_ready = rst_l && grant1_s;
                accept_s   = grant0_s || grant1_s;
                if (accept_s) begin
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                opcode_fi_s = 1'b1;
                state_s     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign rsp_valid   = (state_r == RESP);
    assign rsp_id      = rsp_id_r;
    assign rsp_int     = rsp_int_r;
    assign rsp_invalid = rsp_invalid_r;
    assign rsp_inexact = rsp_inexact_r;
    assign handshake_s = rsp_valid && rsp_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and round-robin pointer update on accept.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            op_float_r  <= {(STD+1){1'b0}};
            op_rm_r     <= 3'd0;
            op_signed_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            prio_r      <= 1'b0;
        end else if (accept_s) begin
            op_float_r  <= grant1_s ? req1_float  : req0_float;
            op_rm_r     <= grant1_s ? req1_rm     : req0_rm;
            op_signed_r <= grant1_s ? req1_signed : req0_signed;
            rsp_id_r    <= grant1_s;
            prio_r      <= !grant1_s;
        end
    end

    // Result capture at the end of the execute cycle; held through RESP.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rsp_int_r     <= 32'd0;
            rsp_invalid_r <= 1'b0;
            rsp_inexact_r <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_int_r     <= cvt_int_s;
            rsp_invalid_r <= cvt_invalid_s;
            rsp_inexact_r <= cvt_inexact_s;
        end
    end

    FPU_Float_to_Int #(
        .STD  (STD),
        .MAN  (MAN),
        .EXP  (EXP),
        .BIAS (BIAS)
    ) u_cvt (
        .rst_l           (rst_l),
        .opcode_FI       (opcode_fi_s),
        .opcode_signed   (op_signed_r),
        .opcode_unsigned (opcode_unsigned_s),
        .rounding_mode   (op_rm_r),
        .float_in        (op_float_r),
        .int_out         (cvt_int_s),
        .invalid         (cvt_invalid_s),
        .inexact         (cvt_inexact_s)
    );

`ifdef F2I_FLAG_ACCUM_EN
    logic [1:0] fflags_acc_r;

    // Sticky flags; a clear coinciding with a handshake keeps only that response.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            fflags_acc_r <= 2'b00;
        end else if (handshake_s) begin
            fflags_acc_r <= (flag_clr ? 2'b00 : fflags_acc_r) | {rsp_invalid_r, rsp_inexact_r};
        end else if (flag_clr) begin
            fflags_acc_r <= 2'b00;
        end
    end

    assign fflags_acc = fflags_acc_r;
`else
    logic unused_flag_inputs_s;
    assign unused_flag_inputs_s = flag_clr ^ handshake_s;
    assign fflags_acc           = 2'b00;
`endif

endmodule

// File: tb/tb_fpu_f2i_arbiter.sv
// Self-checking bench for fpu_f2i_arbiter: a real-arithmetic conversion model and
// a transaction-level arbiter model checked every cycle, plus directed literal vectors.
module tb_fpu_f2i_arbiter;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        req0_valid, req0_ready, req0_signed;
    logic [15:0] req0_float;
    logic [2:0]  req0_rm;
    logic        req1_valid, req1_ready, req1_signed;
    logic [15:0] req1_float;
    logic [2:0]  req1_rm;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_invalid, rsp_inexact, flag_clr;
    logic [31:0] rsp_int;
    logic [1:0]  fflags_acc;

    int errs   = 0;
    int checks = 0;

    // model state, written only by the compare process
    bit          m_busy;
    int          m_age;
    bit          m_prio;
    logic [1:0]  m_acc;
    logic [31:0] m_int;
    logic        m_inv, m_inx, m_id;

    always #5 clk = ~clk;

    fpu_f2i_arbiter dut (
        .clk(clk), .rst_l(rst_l),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_float(req0_float),
        .req0_rm(req0_rm), .req0_signed(req0_signed),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_float(req1_float),
        .req1_rm(req1_rm), .req1_signed(req1_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_int(rsp_int),
        .rsp_invalid(rsp_invalid), .rsp_inexact(rsp_inexact),
        .flag_clr(flag_clr), .fflags_acc(fflags_acc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Half-precision to int32 using real arithmetic and the rounding rules directly.
    function automatic void model_conv(input logic [15:0] f, input logic [2:0] rm, input logic sgn,
                                       output logic [31:0] r, output logic inv, output logic inx);
        bit  neg;
        int  ex, mn;
        real mag, fl, fr, rounded, lim;
        neg = f[15];
        ex  = int'(f[14:10]);
        mn  = int'(f[9:0]);
        inv = 1'b0;
        inx = 1'b0;
        r   = 32'd0;
        if (ex == 31) begin
            inv = 1'b1;
            if (mn != 0 || !neg) r = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            else                 r = sgn ? 32'h8000_0000 : 32'h0000_0000;
            return;
        end
        mag = (ex == 0) ? real'(mn) * 2.0 ** (-24) : real'(1024 + mn) * 2.0 ** (ex - 25);
        fl  = $floor(mag);
        fr  = mag - fl;
        case (rm)
            3'd0:    rounded = (fr > 0.5 || (fr == 0.5 && (longint'(fl) % 2) == 1)) ? fl + 1.0 : fl;
            3'd2:    rounded = (neg && fr > 0.0) ? fl + 1.0 : fl;
            3'd3:    rounded = (!neg && fr > 0.0) ? fl + 1.0 : fl;
            3'd4:    rounded = (fr >= 0.5) ? fl + 1.0 : fl;
            default: rounded = fl;
        endcase
        if (sgn) lim = neg ? 2147483648.0 : 2147483647.0;
        else     lim = neg ? 0.0 : 4294967295.0;
        if (rounded > lim) begin
            inv = 1'b1;
            if (neg) r = sgn ? 32'h8000_0000 : 32'h0000_0000;
            else     r = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
        end else begin
            inx = (fr != 0.0);
            r   = neg ? 32'(-longint'(rounded)) : 32'(longint'(rounded));
        end
    endfunction

    // Compare process: every cycle, predict handshakes and outputs from the model.
    initial begin
        bit e_r0, e_r1, e_v;
        forever begin
            @(negedge clk);
            if (!rst_l) begin
                m_busy = 1'b0; m_prio = 1'b0; m_acc = 2'b00;
                chk("rst_ready0", req0_ready, 0);
                chk("rst_ready1", req1_ready, 0);
                chk("rst_valid", rsp_valid, 0);
                chk("rst_id", rsp_id, 0);
                chk("rst_int", rsp_int, 0);
                chk("rst_flags", {rsp_invalid, rsp_inexact}, 0);
                chk("rst_acc", fflags_acc, 0);
            end else begin
                if (m_busy) m_age++;
                e_r0 = !m_busy && req0_valid && (!req1_valid || !m_prio);
                e_r1 = !m_busy && req1_valid && (!req0_valid || m_prio);
                e_v  = m_busy && (m_age >= 2);
                chk("cyc_ready0", req0_ready, e_r0);
                chk("cyc_ready1", req1_ready, e_r1);
                chk("cyc_rsp_valid", rsp_valid, e_v);
                chk("cyc_acc", fflags_acc, m_acc);
                if (e_v) begin
                    chk("cyc_rsp_id", rsp_id, m_id);
                    chk("cyc_rsp_int", rsp_int, m_int);
                    chk("cyc_rsp_flags", {rsp_invalid, rsp_inexact}, {m_inv, m_inx});
                end
`ifdef F2I_FLAG_ACCUM_EN
                if (e_v && rsp_ready) m_acc = (flag_clr ? 2'b00 : m_acc) | {m_inv, m_inx};
                else if (flag_clr)    m_acc = 2'b00;
`endif
                if (e_v && rsp_ready) m_busy = 1'b0;
                if (e_r0) begin
                    model_conv(req0_float, req0_rm, req0_signed, m_int, m_inv, m_inx);
                    m_busy = 1'b1; m_age = 0; m_id = 1'b0; m_prio = 1'b1;
                end else if (e_r1) begin
                    model_conv(req1_float, req1_rm, req1_signed, m_int, m_inv, m_inx);
                    m_busy = 1'b1; m_age = 0; m_id = 1'b1; m_prio = 1'b0;
                end
            end
        end
    end

    task automatic set_req(input bit id, input logic [15:0] f, input logic [2:0] rm, input bit sgn);
        if (id) begin req1_float = f; req1_rm = rm; req1_signed = sgn; req1_valid = 1'b1; end
        else    begin req0_float = f; req0_rm = rm; req0_signed = sgn; req0_valid = 1'b1; end
    endtask

    task automatic wait_accept(input bit id, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 20) begin n++; @(negedge clk); end
        chk({name, "_accept_seen"}, (n < 20), 1);
    endtask

    task automatic wait_rsp(input string name);
        int lat;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
        chk({name, "_latency"}, lat, 2);
    endtask

    // One directed request with literal expectations, also pinning the model.
    task automatic run_req(input bit id, input logic [15:0] f, input logic [2:0] rm, input bit sgn,
                           input logic [31:0] e_int, input bit e_inv, input bit e_inx, input string name);
        logic [31:0] mi;
        logic mv, mx;
        model_conv(f, rm, sgn, mi, mv, mx);
        chk({name, "_model"}, {mi}, e_int);
        chk({name, "_model_flags"}, {mv, mx}, {e_inv, e_inx});
        @(posedge clk); #1;
        set_req(id, f, rm, sgn);
        rsp_ready = 1'b1;
        wait_accept(id, name);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(name);
        chk({name, "_int"}, rsp_int, e_int);
        chk({name, "_flags"}, {rsp_invalid, rsp_inexact}, {e_inv, e_inx});
        chk({name, "_id"}, rsp_id, id);
        @(posedge clk); #1;
    endtask

    initial begin
        int grants[$];
        int n;
        logic [1:0] acc_before, acc_after;
`ifdef F2I_FLAG_ACCUM_EN
        acc_before = 2'b11; acc_after = 2'b01;
`else
        acc_before = 2'b00; acc_after = 2'b00;
`endif
        rst_l = 1'b0; rsp_ready = 1'b1; flag_clr = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_float = 16'h3E00; req0_rm = 3'd0; req0_signed = 1'b1;
        req1_float = 16'h4100; req1_rm = 3'd4; req1_signed = 1'b1;
        // both requesters valid straight out of reset
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
        n = 0;
        while (grants.size() < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (req0_valid && req0_ready) grants.push_back(0);
            if (req1_valid && req1_ready) grants.push_back(1);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_count", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) chk("rr_grant", grants[i], i % 2);
        repeat (4) @(posedge clk);

        run_req(0, 16'h3E00, 3'd0, 1'b1, 32'd2,         1'b0, 1'b1, "r0_1p5_rne");
        run_req(1, 16'h4100, 3'd0, 1'b1, 32'd2,         1'b0, 1'b1, "r1_2p5_rne");
        run_req(1, 16'h4100, 3'd4, 1'b1, 32'd3,         1'b0, 1'b1, "r1_2p5_rmm");
        run_req(0, 16'hBC00, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "r0_m1_signed");
        run_req(0, 16'hBC00, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "r0_m1_unsigned");
        run_req(1, 16'h7C00, 3'd0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, "r1_inf_signed");
        run_req(0, 16'h3E00, 3'd5, 1'b1, 32'd1,         1'b0, 1'b1, "r0_rm101_trunc");
        run_req(1, 16'hBE00, 3'd2, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, "r1_m1p5_rdn");
        run_req(0, 16'hBE00, 3'd3, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, "r0_m1p5_rup");
        run_req(1, 16'h3400, 3'd3, 1'b0, 32'd1,         1'b0, 1'b1, "r1_0p25_rup_u");
        run_req(0, 16'h7BFF, 3'd1, 1'b0, 32'd65504,     1'b0, 1'b0, "r0_max_half_u");
        run_req(1, 16'h7E00, 3'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "r1_nan_u");

        // response stall with a competing requester, then clear coincident with handshake
        chk("acc_before_clr", fflags_acc, acc_before);
        @(posedge clk); #1;
        set_req(0, 16'h3E00, 3'd0, 1'b1);
        rsp_ready = 1'b0;
        wait_accept(0, "stall");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req(1, 16'h4100, 3'd0, 1'b1);
        wait_rsp("stall");
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_int", rsp_int, 32'd2);
            chk("stall_flags", {rsp_invalid, rsp_inexact}, 2'b01);
            chk("stall_ready1", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1; flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("acc_clr_with_hs", fflags_acc, acc_after);
        chk("after_hs_valid", rsp_valid, 0);

        // reset while the conversion is executing
        @(posedge clk); #1;
        set_req(0, 16'h4100, 3'd0, 1'b1);
        wait_accept(0, "rst_exec");
        @(posedge clk); #1;
        req0_valid = 1'b0; rst_l = 1'b0;
        @(negedge clk);
        chk("rst_exec_valid", rsp_valid, 0);
        chk("rst_exec_int", rsp_int, 0);
        chk("rst_exec_acc", fflags_acc, 0);
        @(posedge clk); #1;
        rst_l = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        run_req(0, 16'h3E00, 3'd0, 1'b1, 32'd2, 1'b0, 1'b1, "post_rst_req");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_f2i_arbiter.md
FPU_F2I_ARBITER -- requirements
Module: fpu_f2i_arbiter

Interface
REQ-001 SHALL have parameter STD, default 15, meaning float operand MSB index (operand width STD+1).
REQ-002 SHALL have parameter MAN, default 9, meaning mantissa MSB index, passed to converter.
REQ-003 SHALL have parameter EXP, default 4, meaning exponent MSB index, passed to converter.
REQ-004 SHALL have parameter BIAS, default 15, meaning exponent bias, passed to converter.
REQ-005 SHALL have port clk, in, 1, meaning the single clock; all state rising-edge.
REQ-006 SHALL have port rst_l, in, 1, meaning reset; asynchronous, active-low.
REQ-007 SHALL have ports reqN_valid, in, 1 and reqN_ready, out, 1 (N=0,1), meaning requester handshake.
REQ-008 SHALL have ports reqN_float, in, STD+1; reqN_rm, in, 3; reqN_signed, in, 1 (1=signed, 0=unsigned), meaning operand, rounding mode, conversion type.
REQ-009 SHALL have ports rsp_valid, out, 1 and rsp_ready, in, 1, meaning response handshake.
REQ-010 SHALL have ports rsp_id, out, 1; rsp_int, out, 32; rsp_invalid, out, 1; rsp_inexact, out, 1, meaning requester index, result, flags.
REQ-011 SHALL have ports flag_clr, in, 1 and fflags_acc, out, 2 ({invalid, inexact}), meaning sticky flag clear and accumulated flags.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one conversion in flight.
REQ-013 In IDLE, SHALL assert reqN_ready only for the granted requester; no ready in EXEC/RESP.
REQ-014 Grant SHALL be round-robin: single valid wins; both valid -> requester not granted last; pointer resets to favour req0.
REQ-015 On accept (valid&&ready), SHALL register float, rm, signed, id, and enter EXEC.
REQ-016 In EXEC, SHALL drive converter with opcode_FI=1, opcode_signed=signed, opcode_unsigned=~signed; opcode_FI=0 in all other states.
REQ-017 At end of EXEC, SHALL register converter int/invalid/inexact and enter RESP; latency accept edge to rsp_valid high = 2 cycles.
REQ-018 In RESP, rsp_valid SHALL be 1 and rsp_* SHALL hold stable until rsp_ready; on handshake -> IDLE.
REQ-019 Peak throughput SHALL be one conversion per 3 cycles; new accept not earlier than cycle after response handshake.
REQ-020 rm 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 SHALL pass unmodified (behave as RTZ).
REQ-021 On response handshake, fflags_acc SHALL OR in {rsp_invalid, rsp_inexact}.
REQ-022 flag_clr SHALL zero fflags_acc; if coincident with handshake, fflags_acc SHALL equal that response's flags.

Reset
REQ-023 rst_l low SHALL force IDLE, rsp_valid=0, reqN_ready=0, rsp_id=0, rsp_int=0, flags=0, fflags_acc=0, grant pointer to req0.
REQ-024 Reset mid-EXEC/RESP SHALL drop the transaction; no response after release.

Configuration
REQ-025 With F2I_FLAG_ACCUM_EN defined, SHALL include fflags_acc register per REQ-021/022.
REQ-026 Without F2I_FLAG_ACCUM_EN, fflags_acc SHALL be constant 0 and flag_clr ignored; no register.

Structure
REQ-027 Shared package SHALL hold FSM state enum (IDLE, EXEC, RESP) and rounding-mode constants.
REQ-028 SHALL instantiate one sub-module, existing FPU_Float_to_Int, with STD/MAN/EXP/BIAS and rst_l passed through.

Verification
REQ-029 req0 0x3E00 (1.5), rm=000, signed -> rsp_int=2, inexact=1, invalid=0, rsp_valid 2 cycles after accept.
REQ-030 req1 0x4100 (2.5) rm=000 -> 2; rm=100 -> 3; both inexact=1, rsp_id=1.
REQ-031 req0 0xBC00 (-1.0) signed -> 0xFFFFFFFF, invalid=0; unsigned -> 0x00000000, invalid=1; req1 0x7C00 signed -> 0x7FFFFFFF, invalid=1.
REQ-032 Both valid continuously from reset -> grants 0,1,0,1; each response id matches.
REQ-033 rsp_ready low 5 cycles in RESP -> rsp_* stable, no ready asserted; flag_clr with handshake -> fflags_acc = that response's flags.
REQ-034 rst_l low during EXEC -> all outputs zero; after release no rsp_valid until new request.
